toeplitz_seed_shifter: RTL
==========================

// Module: toeplitz_seed_shifter
// PURPOSE
//  Parametrised Toeplitz seed-row generator. It loads a SEED_W-bit seed and waits a
//  programmable pipeline-fill delay. It then emits exactly ROWS successive Toeplitz rows,
//  each formed by shifting LANES fresh bits from the bit source into the LSBs.
//  It sits between the seed/bit FIFOs and the row-AND/XOR summing stage.
//  Unlike the fixed 3072x1 shifter, it supports a stall on bits_valid and a multi-bit shift.
//  It also reports completion with an explicit done pulse.
// PARAMETERS
//  SEED_W   3072  seed / row width in bits
//  ROWS     4096  rows emitted per seed load (>=1)
//  LANES    1     bits shifted in per row (1..SEED_W-1)
//  PRE_DLY  4     cycles spent in FILL between LOAD and first row (>=1)
// PORTS
//  clk_in        in   1        single clock, all logic posedge
//  rst           in   1        synchronous reset, active-low
//  shift_en      in   1        start request, sampled in IDLE/DONE only
//  seed          in   SEED_W   seed word, captured in LOAD
//  shift_bits    in   LANES    fresh bits; shift_bits[0] lands at row LSB
//  bits_valid    in   1        shift_bits valid this cycle
//  rd_en         out  1        read-enable to bit source FIFO
//  shift_ack     out  1        1-cycle pulse: seed captured
//  sum_en        out  1        summing stage enable, high for whole RUN
//  row_valid     out  1        shift_result holds a new row this cycle
//  shift_result  out  SEED_W   current Toeplitz row
//  done          out  1        1-cycle pulse after last row
//  busy          out  1        high in every state except IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset (rst==0 at a clk_in edge) forces every output,
//    the seed cache, row_cnt and dly_cnt to 0, and the state to IDLE. This also applies mid-operation.
//  - IDLE: outputs 0. On shift_en==1 go to LOAD.
//  - LOAD (1 cycle): seed_cache<=seed; shift_ack<=1; rd_en<=1; dly_cnt<=0. Go to FILL.
//  - FILL: shift_ack<=0; dly_cnt++. On the PRE_DLY-th FILL cycle: sum_en<=1, row_cnt<=0, go to RUN.
//  - RUN, when bits_valid==1:
//      shift_result<=seed_cache;
//      seed_cache<={seed_cache[SEED_W-LANES-1:0],shift_bits};
//      row_valid<=1; row_cnt++.
//    When bits_valid==0: seed_cache, shift_result and row_cnt hold; row_valid<=0.
//  - Row r (0-based) = seed shifted left by r*LANES, with the consumed bits in the LSBs.
//    Row 0 = the unmodified seed. The shift truncates MSBs (no carry).
//  - The accepted row with row_cnt==ROWS-1 is the last. On the next edge: row_valid<=0,
//    sum_en<=0, rd_en<=0, done<=1, go to DONE. Exactly ROWS rows are emitted, never ROWS+1.
//  - DONE (1 cycle): done<=0. If shift_en==1 go straight to LOAD (back-to-back); else go to IDLE.
//  - shift_en is ignored in LOAD/FILL/RUN; no queueing.
//  - shift_result holds its last row until the next accepted row or reset.
//  - rd_en stays high from LOAD through the last RUN cycle, independent of bits_valid.
//  - row_cnt width is $clog2(ROWS+1); dly_cnt width is $clog2(PRE_DLY+1).
// TESTING (SEED_W=8, ROWS=4, LANES=1, PRE_DLY=2 unless noted)
//  1. Hold rst=0 for 2 cycles, then release -> all outputs 0, busy=0; idle with shift_en=0 -> still 0.
//  2. Pulse shift_en, seed=8'hA5, bits 1,0,1,1 with bits_valid=1 continuously.
//     Expect: shift_ack 1 cycle; sum_en after 2 FILL cycles; row_valid x4.
//     Expect shift_result A5,4B,96,2D; done pulse the cycle after the last row; sum_en/rd_en low with done.
//  3. As test 2, but bits_valid pattern 1,0,0,1,1,0,1.
//     Expect: 4 rows only (A5,4B,96,2D); row_valid low and shift_result held during gaps.
//  4. LANES=2, seed=8'hA5, shift_bits=2'b11 each cycle -> rows A5,97,5F,7F.
//  5. Assert rst=0 after the 2nd row -> next edge: all outputs 0, IDLE.
//     A new shift_en with seed 8'h3C then yields row 0 = 3C.
//  6. Hold shift_en=1 throughout, seeds A5 then 3C.
//     Expect: shift_en ignored during RUN; DONE->LOAD back-to-back; 2nd shift_ack 1 cycle after done.
//     Expect second row 0 = 3C.

Source files
------------

// File: rtl/toeplitz_seed_shifter.sv
// Toeplitz seed-row generator: captures a seed, waits a fill delay, then emits ROWS rows
// with LANES fresh bits shifted into the LSBs for each accepted row.
module toeplitz_seed_shifter #(
    parameter int SEED_W  = 3072,
    parameter int ROWS    = 4096,
    parameter int LANES   = 1,
    parameter int PRE_DLY = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              shift_en,
    input  logic [SEED_W-1:0] seed,
    input  logic [LANES-1:0]  shift_bits,
    input  logic              bits_valid,
    output logic              rd_en,
    output logic              shift_ack,
    output logic              sum_en,
    output logic              row_valid,
    output logic [SEED_W-1:0] shift_result,
    output logic              done,
    output logic              busy
);

    localparam int RCW = $clog2(ROWS + 1);
    localparam int DCW = $clog2(PRE_DLY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SEED_W-1:0] cache_q, cache_d;
    logic [SEED_W-1:0] result_q, result_d;
    logic [RCW-1:0]    row_cnt_q, row_cnt_d;
    logic [DCW-1:0]    dly_cnt_q, dly_cnt_d;
    logic              rd_en_q, rd_en_d;
    logic              ack_q, ack_d;
    logic              sum_en_q, sum_en_d;
    logic              row_valid_q, row_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cache_d     = cache_q;
        result_d    = result_q;
        row_cnt_d   = row_cnt_q;
        dly_cnt_d   = dly_cnt_q;
        rd_en_d     = rd_en_q;
        sum_en_d    = sum_en_q;
        ack_d       = 1'b0;
        row_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (shift_en) state_d = S_LOAD;
            end
            S_LOAD: begin
                cache_d   = seed;
                ack_d     = 1'b1;
                rd_en_d   = 1'b1;
                dly_cnt_d = '0;
                state_d   = S_FILL;
            end
            S_FILL: begin
                dly_cnt_d = dly_cnt_q + DCW'(1);
                if (dly_cnt_q == DCW'(PRE_DLY - 1)) begin
                    sum_en_d  = 1'b1;
                    row_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // row_cnt reaching ROWS means the last row has already been emitted
                if (row_cnt_q == RCW'(ROWS)) begin
                    sum_en_d = 1'b0;
                    rd_en_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (bits_valid) begin
                    result_d    = cache_q;
                    cache_d     = {cache_q[SEED_W-LANES-1:0], shift_bits};
                    row_valid_d = 1'b1;
                    row_cnt_d   = row_cnt_q + RCW'(1);
                end
            end
            S_DONE: begin
                state_d = shift_en ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cache_q     <= '0;
            result_q    <= '0;
            row_cnt_q   <= '0;
            dly_cnt_q   <= '0;
            rd_en_q     <= 1'b0;
            ack_q       <= 1'b0;
            sum_en_q    <= 1'b0;
            row_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cache_q     <= cache_d;
            result_q    <= result_d;
            row_cnt_q   <= row_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            rd_en_q     <= rd_en_d;
            ack_q       <= ack_d;
            sum_en_q    <= sum_en_d;
            row_valid_q <= row_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_en        = rd_en_q;
    assign shift_ack    = ack_q;
    assign sum_en       = sum_en_q;
    assign row_valid    = row_valid_q;
    assign shift_result = result_q;
    assign done         = done_q;
    assign busy         = busy_q;

endmodule
